// File: rtl/sky_pkg.sv
// Shared opcode constants, register-address width and controller state type
// for the XU pipeline control slice.
package sky_pkg;

    localparam int REG_ADDR_W = 4;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ITYPE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } ctrl_state_t;

    // Which register sources an opcode reads: bit 0 = rs1, bit 1 = rs2.
    function automatic logic [1:0] src_use(input logic [3:0] opcode);
        case (opcode)
            OP_RTYPE, OP_STORE: return 2'b11;
            OP_ITYPE, OP_LOAD:  return 2'b01;
            default:            return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/sky_pipeline_ctrl_if.sv
// Pipeline-side view of the stall/bubble sequencer: hazard sources, dmem
// handshake, stall/bubble controls and performance counters.
interface sky_pipeline_ctrl_if
    import sky_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic                  id_valid;
    logic [31:0]           id_instr;
    logic                  ex_valid;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  mem_valid;
    logic                  mem_reg_write;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_req;
    logic                  dmem_ack;
    logic                  clr_counters;

    logic                  stall_if;
    logic                  stall_id;
    logic                  bubble_ex;
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  bubble_wb;
    logic                  fault;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      hazard_cycles;

    // Pipeline stages drive the request side.
    modport master (
        output id_valid, id_instr, ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr,
               mem_valid, mem_reg_write, mem_rd_addr, mem_req, dmem_ack, clr_counters,
        input  stall_if, stall_id, bubble_ex, stall_ex, stall_mem, bubble_wb, fault,
               stall_cycles, hazard_cycles
    );

    // The controller consumes the request side.
    modport slave (
        input  id_valid, id_instr, ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr,
               mem_valid, mem_reg_write, mem_rd_addr, mem_req, dmem_ack, clr_counters,
        output stall_if, stall_id, bubble_ex, stall_ex, stall_mem, bubble_wb, fault,
               stall_cycles, hazard_cycles
    );

endinterface

// File: rtl/sky_hazard_detect.sv
// Combinational RAW hazard check between the instruction in ID and the
// producers in EX/MEM that ID cannot yet see through WB forwarding.
module sky_hazard_detect
    import sky_pkg::*;
#(
    parameter bit EX_FWD = 1'b0
) (
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic                  ex_valid,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    output logic                  hazard
);

    logic [1:0]            use_src;
    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [1:0]            src_hit;
    logic                  ex_live;
    logic                  mem_live;
    logic                  unused_instr_bits;

    assign use_src     = src_use(id_instr[31:28]);
    assign src_addr[0] = id_instr[27:24];
    assign src_addr[1] = id_instr[23:20];
    assign unused_instr_bits = ^id_instr[19:0];

    // With EX/MEM forwarding downstream only a load in EX still blocks ID.
    assign ex_live  = ex_valid & ex_reg_write & (EX_FWD ? ex_mem_read : 1'b1);
    assign mem_live = mem_valid & mem_reg_write & ~EX_FWD;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = use_src[gi] && (src_addr[gi] != '0) &&
                                 ((ex_live  && (src_addr[gi] == ex_rd_addr)) ||
                                  (mem_live && (src_addr[gi] == mem_rd_addr)));
        end
    endgenerate

    assign hazard = id_valid & (|src_hit);

endmodule

// File: rtl/sky_pipeline_ctrl.sv
// Stall/bubble sequencer: data-hazard bubbles, dmem wait handshake with a
// watchdog that latches a sticky fault, and saturating stall/hazard counters.
module sky_pipeline_ctrl
    import sky_pkg::*;
#(
    parameter bit EX_FWD      = 1'b0,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic                clk,
    input logic                reset,
    sky_pipeline_ctrl_if.slave ctrl
);

    localparam int TO_W = $clog2(MEM_TIMEOUT) + 1;
    // Entry cycle in RUN is the first stall, so MEM_WAIT gives up after MEM_TIMEOUT-1 more.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 2);

    ctrl_state_t     state_reg, state_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            fault_reg;
    logic            hazard;
    logic            mem_stall, hazard_stall, fault_stall;

    sky_hazard_detect #(
        .EX_FWD (EX_FWD)
    ) u_hazard (
        .id_valid      (ctrl.id_valid),
        .id_instr      (ctrl.id_instr),
        .ex_valid      (ctrl.ex_valid),
        .ex_reg_write  (ctrl.ex_reg_write),
        .ex_mem_read   (ctrl.ex_mem_read),
        .ex_rd_addr    (ctrl.ex_rd_addr),
        .mem_valid     (ctrl.mem_valid),
        .mem_reg_write (ctrl.mem_reg_write),
        .mem_rd_addr   (ctrl.mem_rd_addr),
        .hazard        (hazard)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= RUN;
            to_cnt_reg <= '0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
            if (state_next == FAULT) begin
                fault_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        to_cnt_next  = to_cnt_reg;
        mem_stall    = 1'b0;
        hazard_stall = 1'b0;
        fault_stall  = 1'b0;
        case (state_reg)
            RUN: begin
                if (ctrl.mem_req && !ctrl.dmem_ack) begin
                    mem_stall   = 1'b1;
                    state_next  = MEM_WAIT;
                    to_cnt_next = '0;
                end else if (hazard) begin
                    hazard_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!ctrl.dmem_ack) begin
                    mem_stall = 1'b1;
                    if (to_cnt_reg == TO_LAST) begin
                        state_next = FAULT;
                    end else begin
                        to_cnt_next = to_cnt_reg + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    // The ack cycle behaves like RUN with no request, so a held-back hazard bubbles now.
                    state_next   = RUN;
                    hazard_stall = hazard;
                end
            end
            FAULT: begin
                fault_stall = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign ctrl.stall_if  = mem_stall | hazard_stall | fault_stall;
    assign ctrl.stall_id  = mem_stall | hazard_stall | fault_stall;
    assign ctrl.bubble_ex = hazard_stall;
    assign ctrl.stall_ex  = mem_stall | fault_stall;
    assign ctrl.stall_mem = mem_stall | fault_stall;
    assign ctrl.bubble_wb = mem_stall | fault_stall;
    assign ctrl.fault     = fault_reg;

    logic [1:0] cnt_inc;
    assign cnt_inc = {hazard_stall, ctrl.stall_if};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (ctrl.clr_counters) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign ctrl.stall_cycles  = g_perf[0].cnt_reg;
    assign ctrl.hazard_cycles = g_perf[1].cnt_reg;

endmodule

// File: tb/tb_sky_pipeline_ctrl.sv
// Directed scoreboard bench: dut_a (EX_FWD=0, MEM_TIMEOUT=4, CNT_W=4) and
// dut_b (EX_FWD=1, MEM_TIMEOUT=64, CNT_W=32) share the same stimulus.
module tb_sky_pipeline_ctrl;
    import sky_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sky_pipeline_ctrl_if #(.CNT_W(4))  ifa ();
    sky_pipeline_ctrl_if #(.CNT_W(32)) ifb ();

    sky_pipeline_ctrl #(.EX_FWD(1'b0), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
        .clk (clk), .reset (reset), .ctrl (ifa.slave)
    );
    sky_pipeline_ctrl #(.EX_FWD(1'b1), .MEM_TIMEOUT(64), .CNT_W(32)) dut_b (
        .clk (clk), .reset (reset), .ctrl (ifb.slave)
    );

    // {stall_if, stall_id, bubble_ex, stall_ex, stall_mem, bubble_wb, fault}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_HAZ  = 7'b1110000;
    localparam logic [6:0] O_MEM  = 7'b1101110;
    localparam logic [6:0] O_FLT  = 7'b1101111;

    typedef struct {
        string      tag;
        int         sel;
        logic [6:0] exp;
    } sb_t;
    sb_t sb_q[$];

    int compared = 0;
    int mismatched = 0;

    logic        id_valid, ex_valid, ex_reg_write, ex_mem_read;
    logic        mem_valid, mem_reg_write, mem_req, dmem_ack, clr_counters;
    logic [31:0] id_instr;
    logic [3:0]  ex_rd_addr, mem_rd_addr;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] rs1,
                                       input logic [3:0] rs2);
        return {op, rs1, rs2, 20'h0};
    endfunction

    function automatic logic [6:0] obs(input int sel);
        if (sel == 0)
            return {ifa.stall_if, ifa.stall_id, ifa.bubble_ex, ifa.stall_ex,
                    ifa.stall_mem, ifa.bubble_wb, ifa.fault};
        return {ifb.stall_if, ifb.stall_id, ifb.bubble_ex, ifb.stall_ex,
                ifb.stall_mem, ifb.bubble_wb, ifb.fault};
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_instr = '0; ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_rd_addr = '0; mem_valid = 0; mem_reg_write = 0; mem_rd_addr = '0;
        mem_req = 0; dmem_ack = 0; clr_counters = 0;
    endtask

    task automatic apply();
        ifa.id_valid = id_valid;       ifb.id_valid = id_valid;
        ifa.id_instr = id_instr;       ifb.id_instr = id_instr;
        ifa.ex_valid = ex_valid;       ifb.ex_valid = ex_valid;
        ifa.ex_reg_write = ex_reg_write; ifb.ex_reg_write = ex_reg_write;
        ifa.ex_mem_read = ex_mem_read; ifb.ex_mem_read = ex_mem_read;
        ifa.ex_rd_addr = ex_rd_addr;   ifb.ex_rd_addr = ex_rd_addr;
        ifa.mem_valid = mem_valid;     ifb.mem_valid = mem_valid;
        ifa.mem_reg_write = mem_reg_write; ifb.mem_reg_write = mem_reg_write;
        ifa.mem_rd_addr = mem_rd_addr; ifb.mem_rd_addr = mem_rd_addr;
        ifa.mem_req = mem_req;         ifb.mem_req = mem_req;
        ifa.dmem_ack = dmem_ack;       ifb.dmem_ack = dmem_ack;
        ifa.clr_counters = clr_counters; ifb.clr_counters = clr_counters;
    endtask

    // Drive the current inputs, record the expected outputs, then check them
    // mid-cycle and advance past the next rising edge.
    task automatic step(input int sel, input string tag, input logic [6:0] exp);
        sb_t e;
        logic [6:0] o;
        apply();
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb_q.push_back(e);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs(e.sel);
            compared++;
            assert (o === e.exp) else begin
                mismatched++;
                $error("FAIL %s observed=%b expected=%b", e.tag, o, e.exp);
            end
            $display("step %s dut=%0d outputs=%b", e.tag, e.sel, o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input int sel, input string tag, input logic [31:0] exp_stall,
                           input logic [31:0] exp_haz);
        logic [31:0] s, h;
        s = (sel == 0) ? {28'h0, ifa.stall_cycles}  : ifb.stall_cycles;
        h = (sel == 0) ? {28'h0, ifa.hazard_cycles} : ifb.hazard_cycles;
        compared++;
        assert (s === exp_stall) else begin
            mismatched++;
            $error("FAIL %s_stall_cycles observed=%0d expected=%0d", tag, s, exp_stall);
        end
        compared++;
        assert (h === exp_haz) else begin
            mismatched++;
            $error("FAIL %s_hazard_cycles observed=%0d expected=%0d", tag, h, exp_haz);
        end
        $display("counters %s dut=%0d stall=%0d hazard=%0d", tag, sel, s, h);
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        reset = 1'b1;
        step(0, {tag, "_a"}, O_NONE);
        step(1, {tag, "_b"}, O_NONE);
        chk_cnt(0, tag, 0, 0);
        chk_cnt(1, tag, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();

        // RAW hazard without forwarding: EX then MEM producer.
        do_reset("reset0");
        id_valid = 1; id_instr = mk(OP_RTYPE, 4'd3, 4'd0);
        ex_valid = 1; ex_reg_write = 1; ex_rd_addr = 4'd3;
        step(0, "nofwd_ex", O_HAZ);
        ex_valid = 0; mem_valid = 1; mem_reg_write = 1; mem_rd_addr = 4'd3;
        step(0, "nofwd_mem", O_HAZ);
        mem_valid = 0;
        step(0, "nofwd_clear", O_NONE);
        chk_cnt(0, "nofwd", 2, 2);

        // Source-usage boundaries against an EX producer of r3.
        ex_valid = 1; ex_reg_write = 1; ex_rd_addr = 4'd3;
        id_instr = mk(4'd4, 4'd3, 4'd3);
        step(0, "op4_nosrc", O_NONE);
        id_instr = mk(OP_ITYPE, 4'd1, 4'd3);
        step(0, "itype_rs2", O_NONE);
        id_instr = mk(OP_STORE, 4'd1, 4'd3);
        step(0, "store_rs2", O_HAZ);
        id_valid = 0;
        step(0, "id_invalid", O_NONE);
        id_valid = 1; id_instr = mk(OP_RTYPE, 4'd0, 4'd0); ex_rd_addr = 4'd0;
        step(0, "r0_never", O_NONE);

        // EX forwarding: only a load in EX blocks.
        do_reset("reset1");
        id_valid = 1; id_instr = mk(OP_STORE, 4'd1, 4'd5);
        ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_rd_addr = 4'd5;
        step(1, "fwd_load", O_HAZ);
        ex_mem_read = 0;
        step(1, "fwd_alu", O_NONE);
        ex_valid = 0; mem_valid = 1; mem_reg_write = 1; mem_rd_addr = 4'd5;
        step(1, "fwd_mem_ignored", O_NONE);
        mem_valid = 0; ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 4'd0;
        id_instr = mk(OP_LOAD, 4'd0, 4'd0);
        step(1, "fwd_r0", O_NONE);
        chk_cnt(1, "fwd", 1, 1);

        // Memory wait: three stall cycles then ack.
        do_reset("reset2");
        mem_req = 1;
        step(0, "mw_1", O_MEM);
        step(0, "mw_2", O_MEM);
        step(0, "mw_3", O_MEM);
        dmem_ack = 1;
        step(0, "mw_ack", O_NONE);
        mem_req = 0; dmem_ack = 0;
        step(0, "mw_back_run", O_NONE);
        mem_req = 1; dmem_ack = 1;
        step(0, "zero_wait", O_NONE);
        chk_cnt(0, "memwait", 3, 0);

        // Memory stall masks the data hazard until the ack cycle.
        dmem_ack = 0;
        id_valid = 1; id_instr = mk(OP_RTYPE, 4'd7, 4'd0);
        ex_valid = 1; ex_reg_write = 1; ex_rd_addr = 4'd7;
        step(0, "mask_1", O_MEM);
        step(0, "mask_2", O_MEM);
        dmem_ack = 1;
        step(0, "mask_ack", O_HAZ);
        mem_req = 0; dmem_ack = 0;
        step(0, "mask_after", O_HAZ);
        chk_cnt(0, "mask", 7, 2);

        // Watchdog timeout: fault after four stall cycles, sticky until reset.
        do_reset("reset3");
        mem_req = 1;
        for (int i = 0; i < 4; i++) step(0, $sformatf("to_wait%0d", i), O_MEM);
        step(0, "to_fault0", O_FLT);
        step(0, "to_fault1", O_FLT);
        dmem_ack = 1;
        step(0, "to_ack_ignored", O_FLT);
        mem_req = 0; dmem_ack = 0;
        step(0, "to_sticky", O_FLT);
        chk_cnt(0, "timeout", 8, 0);
        do_reset("reset4");
        step(0, "after_fault_reset", O_NONE);

        // Counter saturation and clear priority.
        id_valid = 1; id_instr = mk(OP_RTYPE, 4'd3, 4'd0);
        ex_valid = 1; ex_reg_write = 1; ex_rd_addr = 4'd3;
        for (int i = 0; i < 20; i++) step(0, $sformatf("sat%0d", i), O_HAZ);
        chk_cnt(0, "saturate", 15, 15);
        clr_counters = 1;
        step(0, "clr_with_stall", O_HAZ);
        chk_cnt(0, "clear", 0, 0);

        // Reset in the middle of a memory wait.
        clr_counters = 0; id_valid = 0; ex_valid = 0; mem_req = 1;
        step(0, "mid_wait1", O_MEM);
        step(0, "mid_wait2", O_MEM);
        chk_cnt(0, "mid_wait", 2, 0);
        do_reset("reset_mid");
        step(0, "mid_reset_run", O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/sky_pipeline_ctrl.md
Name: sky_pipeline_ctrl

Overview:
Central stall/bubble sequencer for the 5-stage XU pipeline (IF, ID, EX, MEM, WB). It detects RAW hazards between the instruction in ID and producers in EX/MEM; ID forwards only from WB. It also runs the data-memory wait handshake with a watchdog timeout, and keeps stall and hazard performance counters. Outputs drive the `stall` inputs of sky_decode_stage and the other stage registers.

Parameters:
EX_FWD, 0, 1 = EX/MEM forwarding exists downstream, so only a load in EX is a hazard; 0 = any register-writing producer in EX or MEM is a hazard
MEM_TIMEOUT, 64, max MEM_WAIT cycles before FAULT (must be >= 2)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_instr  in  32  ID instruction (opcode[31:28], rs1[27:24], rs2[23:20])
ex_valid  in  1  EX stage valid
ex_reg_write  in  1  EX instruction writes rd
ex_mem_read  in  1  EX instruction is a load
ex_rd_addr  in  4  EX destination
mem_valid  in  1  MEM stage valid
mem_reg_write  in  1  MEM instruction writes rd
mem_rd_addr  in  4  MEM destination
mem_req  in  1  MEM stage is presenting a load/store to dmem
dmem_ack  in  1  dmem completes the request this cycle
clr_counters  in  1  synchronous counter clear
stall_if  out  1  hold PC/fetch register
stall_id  out  1  hold ID register (decode `stall`)
bubble_ex  out  1  load NOP into ID->EX register (reg_write/mem_read/mem_write = 0)
stall_ex  out  1  hold EX register
stall_mem  out  1  hold MEM register
bubble_wb  out  1  WB receives NOP (reg_write = 0)
fault  out  1  sticky dmem timeout
stall_cycles  out  CNT_W  cycles with stall_if = 1
hazard_cycles  out  CNT_W  cycles with bubble_ex = 1

Behaviour:
- Source use by opcode:
  - 0 (R-type) and 3 (store): rs1 and rs2.
  - 1 (I-type) and 2 (load): rs1 only.
  - 4-15: no sources.
  - r0 never matches.
- Data hazard (combinational):
  - Condition: id_valid, and a used source equals a producer rd.
  - EX producer qualified by ex_valid & ex_reg_write, and additionally ex_mem_read when EX_FWD = 1.
  - MEM producer qualified by mem_valid & mem_reg_write; ignored when EX_FWD = 1.
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN.
- RUN:
  - mem_req & !dmem_ack: stall_if = stall_id = stall_ex = stall_mem = bubble_wb = 1, bubble_ex = 0. Next state MEM_WAIT; timeout counter cleared.
  - Otherwise, on a data hazard: stall_if = stall_id = bubble_ex = 1, all others 0.
  - Otherwise all outputs 0.
  - mem_req & dmem_ack in the same cycle is a zero-wait access: no stall.
- MEM_WAIT:
  - The memory stall set (as above) is driven while !dmem_ack. The timeout counter increments each such cycle.
  - On dmem_ack: outputs are evaluated exactly as in RUN with mem_req treated as 0. Data-hazard bubbles therefore resume in that same cycle. Next state RUN.
  - Timeout counter reaching MEM_TIMEOUT-1 without ack: next state FAULT.
- FAULT:
  - fault = 1 (registered); all stall outputs and bubble_wb = 1; bubble_ex = 0.
  - Exits only on reset. dmem_ack is ignored.
- Priority: FAULT > memory stall > data hazard. The data hazard is fully masked during a memory stall.
- Counters:
  - Saturate at all-ones.
  - clr_counters zeroes both counters and has priority over increment in the same cycle.
  - The counters keep counting in FAULT.
- Reset:
  - State RUN, fault = 0, timeout counter = 0, both counters = 0.
  - Stall/bubble outputs are combinational from state and inputs, so they are 0 while reset is held unless a data hazard is presented.
  - Reset mid-MEM_WAIT abandons the access; the pipeline registers are reset at the same time.

Decomposition:
- sky_pkg holds:
  - opcode constants OP_RTYPE = 0, OP_ITYPE = 1, OP_LOAD = 2, OP_STORE = 3;
  - REG_ADDR_W = 4;
  - ctrl_state_t enum {RUN, MEM_WAIT, FAULT}.
- One combinational sub-module, sky_hazard_detect:
  - inputs: id_instr, id_valid, the EX/MEM producer fields and EX_FWD;
  - output: hazard.
- The FSM, watchdog and counters stay in sky_pipeline_ctrl.

Test Plan:
- EX_FWD = 0; ID = R-type rs1 = 3; EX reg_write rd = 3 for 1 cycle, then that producer in MEM the next cycle -> stall_id = bubble_ex = 1 for 2 cycles; hazard_cycles = 2.
- EX_FWD = 1; ID store rs2 = 5; EX load rd = 5 -> 1 bubble. Repeat with EX ALU op rd = 5 -> no stall. rd = 0 -> never a stall.
- mem_req = 1, dmem_ack after 3 wait cycles -> all stalls = 1 for 3 cycles, 0 on the ack cycle; stall_cycles = 3; state back to RUN.
- MEM_TIMEOUT = 4, no ack -> fault rises after 4 stall cycles and stays 1. A later dmem_ack has no effect. Reset clears fault.
- Memory stall and data hazard together -> bubble_ex = 0 during the wait. On the ack cycle the hazard bubble appears (bubble_ex = 1).
- Counter: preload near saturation (CNT_W = 4), stall 20 cycles -> stall_cycles = 15. clr_counters together with a stall -> 0. Assert reset mid-MEM_WAIT -> state RUN and all counters 0.
